// File: rtl/mac_array_ctrl.sv
// Sequencer for a row x col weight-stationary MAC array: kernel load, settle, execute, drain.
// Define MAC_ARRAY_CTRL_TIMEOUT_EN to add the DRAIN watchdog and its err output.
module mac_array_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] kernel_base,
  input  logic [addr_w-1:0] act_base,
  input  logic [len_w-1:0]  num_vec,
  input  logic              valid_last,
  output logic              mem_cen,
  output logic [addr_w-1:0] mem_addr,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              done
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam int SETTLE_N = row + col;
  localparam int WD_N     = 2 * (row + col);
  localparam int CNT_W    = ((len_w > $clog2(WD_N + 1)) ? len_w : $clog2(WD_N + 1)) + 1;
  localparam logic [CNT_W-1:0] KL_LAST = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_N - 1);
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_N - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_KLOAD, S_SETTLE, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_num_last;
  logic [addr_w-1:0] r_kbase, r_abase;
  logic [len_w-1:0]  r_num, r_out_cnt, w_out_nxt;
  logic              w_accept;
  logic              r_cen, w_cen_nxt;
  logic [addr_w-1:0] r_addr, w_addr_nxt;
  logic [1:0]        r_phase, w_phase_nxt, r_inst;
  logic              r_busy, r_done;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  logic              r_err, w_timeout;
`endif

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_num_last = CNT_W'(r_num) - CNT_W'(1);
  // out_cnt saturates at num_vec so surplus valid_last pulses cannot overshoot the exit compare
  assign w_out_nxt  = (valid_last && (r_state != S_IDLE) && (r_out_cnt != r_num)) ?
                      r_out_cnt + len_w'(1) : r_out_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cen_nxt   = 1'b1;
    w_addr_nxt  = r_addr;
    w_phase_nxt = 2'b00;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_KLOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_KLOAD: begin
        w_cen_nxt   = 1'b0;
        w_addr_nxt  = r_kbase + addr_w'(r_cnt);
        w_phase_nxt = 2'b01;
        if (r_cnt == KL_LAST) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == ST_LAST) begin
          w_state_nxt = (r_num != '0) ? S_EXEC : S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_EXEC: begin
        w_cen_nxt   = 1'b0;
        w_addr_nxt  = r_abase + addr_w'(r_cnt);
        w_phase_nxt = 2'b10;
        if (r_cnt == w_num_last) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (w_out_nxt == r_num) begin
          w_state_nxt = S_DONE;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
        end else if (r_cnt == WD_LAST) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one cycle;
  // inst_w is the read tag delayed once more to line up with the 1-cycle SRAM data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_kbase   <= '0;
      r_abase   <= '0;
      r_num     <= '0;
      r_out_cnt <= '0;
      r_cen     <= 1'b1;
      r_addr    <= '0;
      r_phase   <= 2'b00;
      r_inst    <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cen   <= w_cen_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
      r_inst  <= r_phase;
      r_busy  <= (r_state != S_IDLE);
      r_done  <= (r_state == S_DONE);
      if (w_accept) begin
        r_kbase   <= kernel_base;
        r_abase   <= act_base;
        r_num     <= num_vec;
        r_out_cnt <= '0;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
        r_err     <= 1'b0;
`endif
      end else begin
        r_out_cnt <= w_out_nxt;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
        if (w_timeout) r_err <= 1'b1;
`endif
      end
    end
  end

  assign mem_cen  = r_cen;
  assign mem_addr = r_addr;
  assign inst_w   = r_inst;
  assign busy     = r_busy;
  assign done     = r_done;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  assign err      = r_err;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: logs SRAM reads, inst_w tags, busy and done
// each cycle and compares them against a job-level timeline model.
module tb_mac_array_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int LW  = 11;

  logic          clk = 1'b0;
  logic          reset, start, valid_last;
  logic [AW-1:0] kernel_base, act_base;
  logic [LW-1:0] num_vec;
  logic          mem_cen;
  logic [AW-1:0] mem_addr;
  logic [1:0]    inst_w;
  logic          busy, done;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  logic          err;
  logic          err_at_done[$];
  logic          err_after_acc;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_array_ctrl #(.row(ROW), .col(COL), .addr_w(AW), .len_w(LW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .kernel_base(kernel_base), .act_base(act_base), .num_vec(num_vec),
    .valid_last(valid_last), .mem_cen(mem_cen), .mem_addr(mem_addr),
    .inst_w(inst_w), .busy(busy), .done(done)
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  // per-cycle observation log, sampled on the falling edge
  bit            log_en = 1'b0;
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            ins_cyc[$];
  logic [1:0]    ins_val[$];
  int            done_cyc[$];
  int            busy_n, busy_first, busy_last;

  always @(negedge clk) begin
    if (log_en) begin
      if (mem_cen === 1'b0) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(mem_addr);
      end
      if (inst_w !== 2'b00) begin
        ins_cyc.push_back(cyc);
        ins_val.push_back(inst_w);
      end
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
        err_at_done.push_back(err);
`endif
      end
      if (busy === 1'b1) begin
        if (busy_n == 0) busy_first = cyc;
        busy_last = cyc;
        busy_n++;
      end
    end
  end

  // expected timeline of one job
  int            exp_rc[$];
  logic [AW-1:0] exp_ra[$];
  int            exp_ic[$];
  logic [1:0]    exp_iv[$];
  int            exp_done;

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); ins_cyc.delete(); ins_val.delete();
    done_cyc.delete();
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    err_at_done.delete();
`endif
    busy_n = 0; busy_first = -1; busy_last = -1;
  endtask

  // t = edge at which start is accepted; p_last = edge sampling the num-th valid_last
  task automatic build_model(input logic [AW-1:0] kb, input logic [AW-1:0] ab,
                             input int num, input int t, input int p_last);
    int x, d0;
    exp_rc.delete(); exp_ra.delete(); exp_ic.delete(); exp_iv.delete();
    for (int k = 0; k < COL; k++) begin
      exp_rc.push_back(t + 1 + k);
      exp_ra.push_back(kb + AW'(k));
      exp_ic.push_back(t + 2 + k);
      exp_iv.push_back(2'b01);
    end
    x = t + 1 + COL + (ROW + COL);
    for (int v = 0; v < num; v++) begin
      exp_rc.push_back(x + v);
      exp_ra.push_back(ab + AW'(v));
      exp_ic.push_back(x + v + 1);
      exp_iv.push_back(2'b10);
    end
    if (num == 0) begin
      exp_done = t + COL + (ROW + COL) + 1;
    end else begin
      d0 = x + num - 1;
      exp_done = d0 + (((p_last - d0) > 1) ? (p_last - d0) : 1) + 1;
    end
  endtask

  task automatic run_job(input logic [AW-1:0] kb, input logic [AW-1:0] ab, input int num,
                         input int npulse, input int first_off, input int maxgap,
                         input bit inject_start, output int t_acc, output int p_last);
    int sched[$];
    int e0, nxt;
    clear_logs();
    log_en = 1'b1;
    @(posedge clk); #1;
    kernel_base = kb; act_base = ab; num_vec = LW'(num); start = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    start = 1'b0;
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    err_after_acc = err;
`endif
    kernel_base = AW'($urandom); act_base = AW'($urandom); num_vec = LW'($urandom);
    e0 = t_acc + 2 * COL + ROW;
    nxt = e0 + first_off;
    p_last = -1;
    for (int i = 0; i < npulse; i++) begin
      sched.push_back(nxt);
      if (i == num - 1) p_last = nxt;
      nxt += 1 + int'($urandom_range(maxgap, 0));
    end
    for (int c = 0; c < 3000; c++) begin
      valid_last = 1'b0;
      if (sched.size() > 0 && sched[0] == cyc + 1) begin
        valid_last = (done_cyc.size() == 0);
        void'(sched.pop_front());
      end
      start = (inject_start && (cyc + 1 == e0 + 5));
      @(posedge clk); #1;
      if (done_cyc.size() > 0 && cyc >= done_cyc[0] + 2) break;
    end
    valid_last = 1'b0;
    start = 1'b0;
    kernel_base = '0; act_base = '0; num_vec = '0;
    log_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; valid_last = 1'b0;
    kernel_base = '0; act_base = '0; num_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_cen !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b want 1", mem_cen); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
    checks++; if (inst_w !== 2'b00) begin errors++; $display("FAIL reset_inst: got %b want 00", inst_w); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_cen !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset: busy=%b cen=%b want busy=0 cen=1", busy, mem_cen);
    end
  endtask

  task automatic test_kernel_only();
    int t, p;
    run_job(11'h010, 11'h3AB, 0, 0, 0, 0, 1'b0, t, p);
    build_model(11'h010, 11'h3AB, 0, t, p);
    checks++; if (rd_cyc.size() !== COL) begin errors++; $display("FAIL ko_reads: got %0d want %0d", rd_cyc.size(), COL); end
    for (int i = 0; i < COL && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] !== exp_rc[i] || rd_addr[i] !== exp_ra[i]) begin
        errors++; $display("FAIL ko_read%0d: got cyc %0d addr %h want cyc %0d addr %h", i, rd_cyc[i] - t, rd_addr[i], exp_rc[i] - t, exp_ra[i]);
      end
    end
    checks++; if (ins_cyc.size() !== COL) begin errors++; $display("FAIL ko_inst_count: got %0d want %0d", ins_cyc.size(), COL); end
    for (int i = 0; i < ins_cyc.size() && i < COL; i++) begin
      checks++;
      if (ins_cyc[i] !== exp_ic[i] || ins_val[i] !== 2'b01) begin
        errors++; $display("FAIL ko_inst%0d: got T+%0d %b want T+%0d 01", i, ins_cyc[i] - t, ins_val[i], exp_ic[i] - t);
      end
    end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL ko_done_count: got %0d want 1", done_cyc.size()); end
    else begin
      checks++; if (done_cyc[0] !== t + 25) begin errors++; $display("FAIL ko_done_cyc: got T+%0d want T+25", done_cyc[0] - t); end
    end
    checks++;
    if (busy_n !== 25 || busy_first !== t + 1 || busy_last !== t + 25) begin
      errors++; $display("FAIL ko_busy: got %0d cycles T+%0d..T+%0d want 25 cycles T+1..T+25", busy_n, busy_first - t, busy_last - t);
    end
  endtask

  task automatic test_exec_jobs();
    logic [AW-1:0] kb, ab;
    int num, np, off, gap, t, p;
    bit inj;
    for (int s = 0; s < 9; s++) begin
      inj = 1'b0; gap = 0;
      case (s)
        0: begin kb = 11'h000; ab = 11'h040; num = 36; np = 36; off = 20; end
        1: begin kb = 11'h123; ab = 11'h300; num = 12; np = 12; off = 4; gap = 1; inj = 1'b1; end
        2: begin kb = 11'h7FC; ab = 11'h7FE; num = 4; np = 4; off = 2; end
        3: begin kb = 11'h055; ab = 11'h0AA; num = 6; np = 9; off = -20; end
        default: begin
          kb = AW'($urandom); ab = AW'($urandom);
          num = int'($urandom_range(20, 1));
          np = num + int'($urandom_range(2, 0));
          off = int'($urandom_range(num + 25, 0)) - 20;
          gap = int'($urandom_range(2, 0));
        end
      endcase
      run_job(kb, ab, num, np, off, gap, inj, t, p);
      build_model(kb, ab, num, t, p);
      checks++;
      if (rd_cyc.size() !== exp_rc.size()) begin
        errors++; $display("FAIL job%0d_reads: got %0d want %0d", s, rd_cyc.size(), exp_rc.size());
      end
      for (int i = 0; i < rd_cyc.size() && i < exp_rc.size(); i++) begin
        checks++;
        if (rd_cyc[i] !== exp_rc[i] || rd_addr[i] !== exp_ra[i]) begin
          errors++; $display("FAIL job%0d_read%0d: got T+%0d addr %h want T+%0d addr %h", s, i, rd_cyc[i] - t, rd_addr[i], exp_rc[i] - t, exp_ra[i]);
        end
      end
      checks++;
      if (ins_cyc.size() !== exp_ic.size()) begin
        errors++; $display("FAIL job%0d_inst_count: got %0d want %0d", s, ins_cyc.size(), exp_ic.size());
      end
      for (int i = 0; i < ins_cyc.size() && i < exp_ic.size(); i++) begin
        checks++;
        if (ins_cyc[i] !== exp_ic[i] || ins_val[i] !== exp_iv[i]) begin
          errors++; $display("FAIL job%0d_inst%0d: got T+%0d %b want T+%0d %b", s, i, ins_cyc[i] - t, ins_val[i], exp_ic[i] - t, exp_iv[i]);
        end
      end
      checks++;
      if (done_cyc.size() !== 1) begin
        errors++; $display("FAIL job%0d_done_count: got %0d want 1", s, done_cyc.size());
      end else begin
        checks++;
        if (done_cyc[0] !== exp_done) begin
          errors++; $display("FAIL job%0d_done_cyc: got T+%0d want T+%0d", s, done_cyc[0] - t, exp_done - t);
        end
      end
      checks++;
      if (busy_n !== exp_done - t || busy_first !== t + 1) begin
        errors++; $display("FAIL job%0d_busy: got %0d cycles from T+%0d want %0d from T+1", s, busy_n, busy_first - t, exp_done - t);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int t, rc, n;
    clear_logs();
    log_en = 1'b1;
    @(posedge clk); #1;
    kernel_base = 11'h000; act_base = 11'h040; num_vec = LW'(36); start = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    start = 1'b0;
    while (cyc < t + 2 * COL + ROW + 10) begin @(posedge clk); #1; end
    reset = 1'b0;
    rc = cyc;
    #2;
    checks++; if (mem_cen !== 1'b1) begin errors++; $display("FAIL midrst_cen: got %b want 1", mem_cen); end
    checks++; if (inst_w !== 2'b00) begin errors++; $display("FAIL midrst_inst: got %b want 00", inst_w); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 log_en = 1'b0;
    n = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= rc) n++;
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_reads_after: got %0d want 0", n); end
    checks++; if (done_cyc.size() !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", done_cyc.size()); end
  endtask

`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
  task automatic test_watchdog();
    int t, p, want;
    run_job(11'h020, 11'h400, 5, 3, 2, 0, 1'b0, t, p);
    want = t + 2 * COL + ROW + 5 + 2 * (ROW + COL) + 1;
    checks++;
    if (done_cyc.size() !== 1) begin
      errors++; $display("FAIL wd_done_count: got %0d want 1", done_cyc.size());
    end else begin
      checks++; if (done_cyc[0] !== want) begin errors++; $display("FAIL wd_done_cyc: got T+%0d want T+%0d", done_cyc[0] - t, want - t); end
      checks++; if (err_at_done[0] !== 1'b1) begin errors++; $display("FAIL wd_err_at_done: got %b want 1", err_at_done[0]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err_held: got %b want 1", err); end
    run_job(11'h030, 11'h000, 0, 0, 0, 0, 1'b0, t, p);
    checks++; if (err_after_acc !== 1'b0) begin errors++; $display("FAIL wd_err_clear: got %b want 0", err_after_acc); end
    checks++; if (done_cyc.size() !== 1 || err_at_done[0] !== 1'b0) begin
      errors++; $display("FAIL wd_next_job: done pulses %0d want 1 with err 0", done_cyc.size());
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_kernel_only();
    test_exec_jobs();
    test_reset_mid_run();
`ifdef MAC_ARRAY_CTRL_TIMEOUT_EN
    test_watchdog();
`endif
    test_kernel_only();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
